// File: rtl/fft_uart_tx.sv
// Streams 32-bit FIFO words out a UART line, MSB byte first, LSB bit first, 8N1.
// Define UART_PARITY_EN to insert an even-parity bit per byte (8E1).
module fft_uart_tx #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_en,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        word_done,
    output logic [9:0]  word_count
);

    localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
    localparam logic [1:0]  ByteLast = 2'(WORD_BYTES - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [6:0] {
        StIdle   = 7'b0000001,
        StRead   = 7'b0000010,
        StWait   = 7'b0000100,
        StStart  = 7'b0001000,
        StData   = 7'b0010000,
        StStop   = 7'b0100000,
        StParity = 7'b1000000
    } state_e;
`else
    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StRead  = 6'b000010,
        StWait  = 6'b000100,
        StStart = 6'b001000,
        StData  = 6'b010000,
        StStop  = 6'b100000
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        rd_en_q, rd_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [9:0]  count_q, count_d;

    logic        bit_end;
    logic [7:0]  cur_byte;

    assign bit_end  = (baud_q == BaudLast);
    assign cur_byte = shift_q[31:24];

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                if (!uart_en) count_d = '0;
                if (uart_en && !fifo_empty) begin
                    state_d = StRead;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                shift_d = fifo_dout;
                state_d = StStart;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
            end
            StStart: begin
                baud_d = bit_end ? '0 : baud_q + 16'd1;
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            StData: begin
                baud_d = bit_end ? '0 : baud_q + 16'd1;
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^cur_byte;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                baud_d = bit_end ? '0 : baud_q + 16'd1;
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                baud_d = bit_end ? '0 : baud_q + 16'd1;
                if (bit_end) begin
                    if (byte_q == ByteLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        count_d = count_q + 10'd1;
                        tx_d    = 1'b1;
                    end else begin
                        // Next byte starts immediately: no idle gap inside a word.
                        state_d = StStart;
                        byte_d  = byte_q + 2'd1;
                        shift_d = {shift_q[23:0], 8'h00};
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign word_done  = done_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_fft_uart_tx.sv
// Scoreboard bench for fft_uart_tx: a FIFO model feeds words, a line decoder checks frames.
module tb_fft_uart_tx;

    localparam int B = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        fifo_rd_en, tx, busy, word_done;
    logic [9:0]  word_count;

    fft_uart_tx #(.BAUD_DIV(B), .WORD_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_en    (uart_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int reads = 0;
    int done_cnt = 0;
    int since_rise = 0;
    int rd_cyc = -100;
    int word_start = 0;
    int ph = -1;
    int fiw = 0;
    logic prev_rd = 1'b0;
    logic line [0:NB-1];
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * (3 - b))));
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) check(name, 64'(done_cnt), 64'(target));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data valid the cycle after the read strobe.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            check("rd_while_empty", 64'(fifo_empty), 64'd0);
            check("rd_pulse_width", 64'(prev_rd), 64'd0);
            reads++;
            rd_cyc = cyc;
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        end
        prev_rd = fifo_rd_en;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Line decoder and word-level monitor.
    always @(negedge clk) begin
        if (rst) begin
            ph = -1;
            fiw = 0;
        end else begin
            if (ph >= 0) ph++;
            else if (tx == 1'b0) begin
                ph = 0;
                if (fiw == 0) begin
                    word_start = cyc;
                    check("start_latency", 64'(cyc - rd_cyc), 64'd2);
                end
            end
            if (ph >= 0 && (ph % B) == B / 2) begin
                line[ph / B] = tx;
                if (ph / B == NB - 1) begin
                    logic [7:0] d;
                    for (int i = 0; i < 8; i++) d[i] = line[i + 1];
                    check("start_bit", 64'(line[0]), 64'd0);
                    check("stop_bit", 64'(line[NB - 1]), 64'd1);
                    check("busy_in_frame", 64'(busy), 64'd1);
                    if (exp_q.size() == 0) check("unexpected_frame", 64'(d), 64'hFFFF);
                    else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("data_byte", 64'(d), 64'(e));
`ifdef UART_PARITY_EN
                        check("parity_bit", 64'(line[9]), 64'($countones(e) % 2));
`endif
                    end
                    ph = -1;
                    fiw = (fiw + 1) % 4;
                end
            end
            if (word_done) begin
                check("done_timing", 64'(cyc - word_start), 64'(NB * 4 * B));
                check("word_count", 64'(word_count), 64'((since_rise + 1) % 1024));
                check("busy_at_done", 64'(busy), 64'd0);
                check("done_word_boundary", 64'(fiw), 64'd0);
                since_rise++;
                done_cnt++;
            end
        end
    end

    initial begin
        int bad;
        int pushed;
        int n;
        // Reset for two cycles
        repeat (2) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_word_done", 64'(word_done), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;

        // Enabled but empty FIFO: nothing may happen
        uart_en = 1'b1;
        since_rise = 0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        end
        check("idle_empty_activity", 64'(bad), 64'd0);

        // Single known word
        push_word(32'h12345678);
        wait_done(1, 400, "first_word_timeout");
        check("first_word_reads", 64'(reads), 64'd1);

        // Randomized stream with random gaps
        pushed = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            push_word($urandom);
            pushed++;
            repeat ($urandom_range(0, 250)) @(negedge clk);
        end
        wait_done(pushed, 20 * 200, "random_timeout");
        check("random_reads", 64'(reads), 64'(pushed));

        // Enable dropped during byte 1: word completes, no further read
        @(negedge clk);
        push_word(32'hA5A5A5A5);
        push_word(32'h0F1E2D3C);
        pushed += 2;
        n = 0;
        while (fiw != 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte1", 64'(fiw), 64'd1);
        uart_en = 1'b0;
        wait_done(pushed - 1, 300, "en_drop_timeout");
        @(negedge clk);
        check("count_clear_after_drop", 64'(word_count), 64'd0);
        n = reads;
        repeat (50) @(negedge clk);
        check("no_read_while_disabled", 64'(reads), 64'(n));
        check("fifo_word_kept", 64'(fifo_q.size()), 64'd1);
        uart_en = 1'b1;
        since_rise = 0;
        wait_done(pushed, 400, "resume_timeout");

        // Reset during data of byte 2
        @(negedge clk);
        push_word(32'hC3A50F96);
        n = 0;
        while (!(fiw == 2 && ph >= B + 2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte2_data", 64'(fiw), 64'd2);
        n = reads;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 64'(tx), 64'd1);
        check("mid_rst_count", 64'(word_count), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        since_rise = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_reread_after_rst", 64'(reads), 64'(n));
        push_word(32'h5AF00FA5);
        wait_done(done_cnt + 1, 400, "fresh_word_timeout");
        check("fresh_word_reads", 64'(reads), 64'(n + 1));

`ifdef UART_PARITY_EN
        @(negedge clk);
        push_word(32'h01FF0300);
        wait_done(done_cnt + 1, 400, "parity_word_timeout");
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
